dsm_weight_correlator: RTL and testbench

// - Consumes the 1-bit delta-sigma bitstream and correlates it against the four 8-tap weight vectors held by the SPI config block.
// - Per integration period, produces signed sums I1/Q1 (w_cos_1/w_sin_1) and I2/Q2 (w_cos_2/w_sin_2) with a one-cycle valid strobe.
// - Sits between the modulator output and the downstream decision/readout logic.

---
 rtl/dsm_weight_correlator.sv | 137 +++++++++++++
 tb/tb_dsm_weight_correlator.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_weight_correlator.sv
// ============================================================================
// Module  : dsm_weight_correlator
// Brief   : Correlates a 1-bit delta-sigma stream against four 8-tap signed
//           weight vectors and emits I1/Q1/I2/Q2 sums once per period.
//           Optional macro CORR_SAT_EN: saturating accumulators (else wrap).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dsm_weight_correlator #(
    parameter int NUM_WIN = 4,
    parameter int OUT_W   = 12
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    input  logic                    clear,
    input  logic [7:0][4:0]         w_cos_1,
    input  logic [7:0][4:0]         w_sin_1,
    input  logic [7:0][4:0]         w_cos_2,
    input  logic [7:0][4:0]         w_sin_2,
    output logic signed [OUT_W-1:0] i1_out,
    output logic signed [OUT_W-1:0] q1_out,
    output logic signed [OUT_W-1:0] i2_out,
    output logic signed [OUT_W-1:0] q2_out,
    output logic                    out_valid,
    output logic                    ovf
);

    localparam int                 c_WIN_W    = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;
    localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(NUM_WIN - 1);
    localparam logic [OUT_W-1:0]   c_MAX      = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]   c_MIN      = {1'b1, {(OUT_W-1){1'b0}}};

    logic [2:0]             r_tap_cnt;
    logic [c_WIN_W-1:0]     r_win_cnt;
    logic [3:0][7:0][4:0]   r_shadow;
    logic                   r_out_valid;
    logic                   r_ovf;

    logic [3:0][7:0][4:0]   w_live;
    logic [3:0]             w_ch_ovf;
    logic [OUT_W-1:0]       w_out [4];
    logic                   w_accept;
    logic                   w_first;
    logic                   w_last;

    // Channel order: 0=I1 (cos_1), 1=Q1 (sin_1), 2=I2 (cos_2), 3=Q2 (sin_2)
    assign w_live   = {w_sin_2, w_cos_2, w_sin_1, w_cos_1};
    assign w_accept = bit_valid & ~clear;
    assign w_first  = (r_tap_cnt == 3'd0) && (r_win_cnt == '0);
    assign w_last   = (r_tap_cnt == 3'd7) && (r_win_cnt == c_WIN_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tap_cnt   <= '0;
            r_win_cnt   <= '0;
            r_shadow    <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (clear) begin
            r_tap_cnt   <= '0;
            r_win_cnt   <= '0;
            r_out_valid <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_out_valid <= w_accept & w_last;
            if (w_accept) begin
                r_tap_cnt <= r_tap_cnt + 3'd1;
                if (r_tap_cnt == 3'd7) begin
                    r_win_cnt <= w_last ? '0 : r_win_cnt + 1'b1;
                end
                if (w_first) begin
                    r_shadow <= w_live;
                end
                if (|w_ch_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < 4; g++) begin : g_ch
            logic [4:0]       w_wt;
            logic [OUT_W:0]   w_wext;
            logic [OUT_W:0]   w_term;
            logic [OUT_W:0]   w_sum;
            logic [OUT_W-1:0] w_next;
            logic [OUT_W-1:0] r_acc;
            logic [OUT_W-1:0] r_out;

            // First bit of a period uses the live weight it is snapshotting
            assign w_wt   = w_first ? w_live[g][r_tap_cnt] : r_shadow[g][r_tap_cnt];
            assign w_wext = {{(OUT_W-4){w_wt[4]}}, w_wt};
            assign w_term = bit_in ? w_wext : -w_wext;
            assign w_sum  = {r_acc[OUT_W-1], r_acc} + w_term;
            assign w_ch_ovf[g] = w_sum[OUT_W] ^ w_sum[OUT_W-1];

`ifdef CORR_SAT_EN
            assign w_next = w_ch_ovf[g] ? (w_sum[OUT_W] ? c_MIN : c_MAX)
                                        : w_sum[OUT_W-1:0];
`else
            assign w_next = w_sum[OUT_W-1:0];
`endif

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_acc <= '0;
                    r_out <= '0;
                end else if (clear) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    if (w_last) begin
                        r_out <= w_next;
                        r_acc <= '0;
                    end else begin
                        r_acc <= w_next;
                    end
                end
            end

            assign w_out[g] = r_out;
        end
    endgenerate

    assign i1_out    = w_out[0];
    assign q1_out    = w_out[1];
    assign i2_out    = w_out[2];
    assign q2_out    = w_out[3];
    assign out_valid = r_out_valid;
    assign ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_dsm_weight_correlator.sv
// ============================================================================
// Module  : tb_dsm_weight_correlator
// Brief   : Self-checking bench: directed vector table, corner sequences and
//           randomized traffic against an integer reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dsm_weight_correlator;

    localparam int NW  = 4;
    localparam int PER = 8 * NW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 bit_in;
    logic                 bit_valid;
    logic                 clear;
    logic [3:0][7:0][4:0] wt;

    logic signed [11:0] a_out [4];
    logic signed [8:0]  b_out [4];
    logic               a_vld, a_ovf, b_vld, b_ovf;

    dsm_weight_correlator #(.NUM_WIN(NW), .OUT_W(12)) u_dut (
        .clock(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .w_cos_1(wt[0]), .w_sin_1(wt[1]), .w_cos_2(wt[2]),
        .w_sin_2(wt[3]), .i1_out(a_out[0]), .q1_out(a_out[1]), .i2_out(a_out[2]),
        .q2_out(a_out[3]), .out_valid(a_vld), .ovf(a_ovf)
    );

    dsm_weight_correlator #(.NUM_WIN(NW), .OUT_W(9)) u_dut9 (
        .clock(clk), .reset_n(reset_n), .bit_in(bit_in), .bit_valid(bit_valid),
        .clear(clear), .w_cos_1(wt[0]), .w_sin_1(wt[1]), .w_cos_2(wt[2]),
        .w_sin_2(wt[3]), .i1_out(b_out[0]), .q1_out(b_out[1]), .i2_out(b_out[2]),
        .q2_out(b_out[3]), .out_valid(b_vld), .ovf(b_ovf)
    );

    // Reference model: period position, weight snapshot, per-DUT integer sums
    int m_pos;
    int m_vld;
    int m_snap [4][8];
    int m_acc  [2][4];
    int m_out  [2][4];
    int m_ovf  [2];

    int n_chk = 0;
    int n_err = 0;
    int n_vld = 0;

    typedef struct {
        int w;
        int pat;
        int e12;
        int e9;
        int ov9;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0;
        m_vld = 0;
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 8; k++) m_snap[c][k] = 0;
            for (int d = 0; d < 2; d++) begin
                m_acc[d][c] = 0;
                m_out[d][c] = 0;
            end
        end
        m_ovf[0] = 0;
        m_ovf[1] = 0;
    endtask

    task automatic model_step();
        int w, s, wd, hi, lo;
        if (clear) begin
            m_pos = 0;
            m_vld = 0;
            for (int d = 0; d < 2; d++) begin
                m_ovf[d] = 0;
                for (int c = 0; c < 4; c++) m_acc[d][c] = 0;
            end
        end else if (bit_valid) begin
            if (m_pos == 0) begin
                for (int c = 0; c < 4; c++)
                    for (int k = 0; k < 8; k++)
                        m_snap[c][k] = int'($signed(wt[c][k]));
            end
            for (int d = 0; d < 2; d++) begin
                wd = (d == 0) ? 12 : 9;
                hi = (1 << (wd - 1)) - 1;
                lo = -(1 << (wd - 1));
                for (int c = 0; c < 4; c++) begin
                    w = m_snap[c][m_pos % 8];
                    s = m_acc[d][c] + (bit_in ? w : -w);
                    if (s > hi || s < lo) begin
                        m_ovf[d] = 1;
`ifdef CORR_SAT_EN
                        s = (s > hi) ? hi : lo;
`else
                        s = s & ((1 << wd) - 1);
                        if (s > hi) s = s - (1 << wd);
`endif
                    end
                    m_acc[d][c] = s;
                end
            end
            if (m_pos == PER - 1) begin
                for (int d = 0; d < 2; d++)
                    for (int c = 0; c < 4; c++) begin
                        m_out[d][c] = m_acc[d][c];
                        m_acc[d][c] = 0;
                    end
                m_vld = 1;
                m_pos = 0;
            end else begin
                m_pos = m_pos + 1;
                m_vld = 0;
            end
        end else begin
            m_vld = 0;
        end
    endtask

    task automatic compare_all();
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("w12_out%0d", c), int'(a_out[c]), m_out[0][c]);
            chk($sformatf("w9_out%0d", c), int'(b_out[c]), m_out[1][c]);
        end
        chk("w12_valid", int'(a_vld), m_vld);
        chk("w9_valid", int'(b_vld), m_vld);
        chk("w12_ovf", int'(a_ovf), m_ovf[0]);
        chk("w9_ovf", int'(b_ovf), m_ovf[1]);
        if (a_vld) n_vld++;
    endtask

    task automatic step(input logic b, input logic v, input logic c);
        bit_in    = b;
        bit_valid = v;
        clear     = c;
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_all(input int v);
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 8; k++) wt[c][k] = 5'(v);
    endtask

    task automatic chk_all_outs(input string nm, input int e12, input int e9);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("%s_w12_ch%0d", nm, c), int'(a_out[c]), e12);
            chk($sformatf("%s_w9_ch%0d", nm, c), int'(b_out[c]), e9);
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        clear     = 1'b0;
        wt        = '0;
        model_reset();

`ifdef CORR_SAT_EN
        tbl[0] = '{w:   1, pat: 1, e12:   32, e9:   32, ov9: 0};
        tbl[1] = '{w: -16, pat: 0, e12:  512, e9:  255, ov9: 1};
        tbl[2] = '{w:   3, pat: 2, e12:    0, e9:    0, ov9: 0};
        tbl[3] = '{w:  -5, pat: 1, e12: -160, e9: -160, ov9: 0};
        tbl[4] = '{w:  15, pat: 1, e12:  480, e9:  255, ov9: 1};
        tbl[5] = '{w: -16, pat: 1, e12: -512, e9: -256, ov9: 1};
        tbl[6] = '{w: -16, pat: 2, e12:    0, e9:    0, ov9: 0};
`else
        tbl[0] = '{w:   1, pat: 1, e12:   32, e9:   32, ov9: 0};
        tbl[1] = '{w: -16, pat: 0, e12:  512, e9:    0, ov9: 1};
        tbl[2] = '{w:   3, pat: 2, e12:    0, e9:    0, ov9: 0};
        tbl[3] = '{w:  -5, pat: 1, e12: -160, e9: -160, ov9: 0};
        tbl[4] = '{w:  15, pat: 1, e12:  480, e9:  -32, ov9: 1};
        tbl[5] = '{w: -16, pat: 1, e12: -512, e9:    0, ov9: 1};
        tbl[6] = '{w: -16, pat: 2, e12:    0, e9:    0, ov9: 0};
`endif

        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk_all_outs("reset", 0, 0);
        reset_n = 1'b1;

        // Directed vector table: one full period per entry after a clear
        for (int t = 0; t < 7; t++) begin
            set_all(tbl[t].w);
            step(1'b0, 1'b0, 1'b1);
            n_vld = 0;
            for (int i = 0; i < PER; i++) begin
                step((tbl[t].pat == 2) ? (i % 2 == 0) : (tbl[t].pat == 1), 1'b1, 1'b0);
            end
            chk_all_outs($sformatf("vec%0d", t), tbl[t].e12, tbl[t].e9);
            chk($sformatf("vec%0d_pulses", t), n_vld, 1);
            chk($sformatf("vec%0d_ovf12", t), int'(a_ovf), 0);
            chk($sformatf("vec%0d_ovf9", t), int'(b_ovf), tbl[t].ov9);
        end

        // Mid-period weight change only lands in the following period
        set_all(1);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) wt[0][k] = 5'd2;
        for (int i = 0; i < PER - 5; i++) step(1'b1, 1'b1, 1'b0);
        chk("wchg_p1_i1", int'(a_out[0]), 32);
        chk("wchg_p1_q1", int'(a_out[1]), 32);
        n_vld = 0;
        for (int i = 0; i < PER; i++) step(1'b1, 1'b1, 1'b0);
        chk("wchg_p2_i1", int'(a_out[0]), 64);
        chk("wchg_p2_q1", int'(a_out[1]), 32);
        chk("wchg_p2_pulses", n_vld, 1);

        // Sparse valid: 64 cycles alternating valid gives one period
        set_all(1);
        step(1'b0, 1'b0, 1'b1);
        n_vld = 0;
        for (int i = 0; i < 64; i++) step(1'b1, (i % 2 == 0), 1'b0);
        chk("sparse_pulses", n_vld, 1);
        chk_all_outs("sparse", 32, 32);

        // Clear collides with a bit, then async reset mid-period
        set_all(2);
        step(1'b0, 1'b0, 1'b1);
        n_vld = 0;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0);
        chk("clr_no_pulse", n_vld, 0);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk_all_outs("async_rst", 0, 0);
        chk("async_rst_ovf", int'(a_ovf), 0);
        @(posedge clk);
        #1;
        compare_all();
        reset_n = 1'b1;
        n_vld = 0;
        for (int i = 0; i < PER - 1; i++) step(1'b1, 1'b1, 1'b0);
        chk("post_rst_31_pulses", n_vld, 0);
        step(1'b1, 1'b1, 1'b0);
        chk("post_rst_32_pulses", n_vld, 1);
        chk_all_outs("post_rst", 64, 64);

        // Randomized traffic against the model
        for (int c = 0; c < 4; c++)
            for (int k = 0; k < 8; k++) wt[c][k] = 5'($urandom_range(0, 31));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0)
                wt[$urandom_range(0, 3)][$urandom_range(0, 7)] = 5'($urandom_range(0, 31));
            step(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 49) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
